// File: rtl/sdram_rom_loader_if.sv
//----------------------------------------------------------------------------
// sdram_rom_loader_if : hps_io download bus plus the SDRAM port1/port2 write pairs. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface sdram_rom_loader_if #(
  parameter int ADDR_W = 25
) ();
  logic              dl_active;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_wait;
  logic              dl_done;

  logic              port1_req;
  logic              port1_ack;
  logic              port1_we;
  logic [22:0]       port1_a;
  logic [1:0]        port1_ds;
  logic [15:0]       port1_d;

  logic              port2_req;
  logic              port2_ack;
  logic              port2_we;
  logic [22:0]       port2_a;
  logic [1:0]        port2_ds;
  logic [15:0]       port2_d;

  modport master (
    input  dl_active, dl_wr, dl_addr, dl_data, port1_ack, port2_ack,
    output dl_wait, dl_done,
           port1_req, port1_we, port1_a, port1_ds, port1_d,
           port2_req, port2_we, port2_a, port2_ds, port2_d
  );

  modport slave (
    output dl_active, dl_wr, dl_addr, dl_data, port1_ack, port2_ack,
    input  dl_wait, dl_done,
           port1_req, port1_we, port1_a, port1_ds, port1_d,
           port2_req, port2_we, port2_a, port2_ds, port2_d
  );
endinterface

`default_nettype wire

// File: rtl/sdram_rom_loader.sv
//----------------------------------------------------------------------------
// sdram_rom_loader : pairs ROM download bytes into 16-bit SDRAM port1/port2 writes. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module sdram_rom_loader #(
  parameter int                ADDR_W   = 25,
  parameter logic [ADDR_W-1:0] GFX_BASE = 25'h0080000
) (
  input  logic               clk,
  input  logic               reset,
  sdram_rom_loader_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              req_valid_q, req_valid_d;
  logic              req_port_q, req_port_d;
  logic [22:0]       req_a_q, req_a_d;
  logic [1:0]        req_ds_q, req_ds_d;
  logic [15:0]       req_d_q, req_d_d;
  logic              p1_req_q, p1_req_d;
  logic              p2_req_q, p2_req_d;
  logic              act_q;
  logic              armed_q, armed_d;
  logic              done_q, done_d;

  logic              w_wait, w_accept, w_pair, w_load, w_hi;
  logic [1:0]        w_load_ds;
  logic [15:0]       w_load_d;
  logic [ADDR_W-1:0] w_off;
  logic              w_unused_off;

  assign w_wait   = pend_valid_q & req_valid_q;
  assign w_accept = bus.dl_wr & ~w_wait;
  assign w_pair   = pend_valid_q & ~pend_addr_q[0] &
                    (bus.dl_addr == pend_addr_q + ADDR_W'(1));

  // Every REQ load takes its address from the PEND byte, so routing only looks at PEND.
  assign w_hi         = (pend_addr_q >= GFX_BASE);
  assign w_off        = w_hi ? pend_addr_q - GFX_BASE : pend_addr_q;
  assign w_unused_off = ^{w_off[ADDR_W-1:24], w_off[0]};

  always_comb begin
    w_load       = 1'b0;
    w_load_ds    = pend_addr_q[0] ? 2'b10 : 2'b01;
    w_load_d     = {pend_data_q, pend_data_q};
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (w_accept) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = bus.dl_addr;
        pend_data_d  = bus.dl_data;
      end else if (w_pair) begin
        w_load       = 1'b1;
        w_load_ds    = 2'b11;
        w_load_d     = {bus.dl_data, pend_data_q};
        pend_valid_d = 1'b0;
      end else begin
        w_load       = 1'b1;
        pend_addr_d  = bus.dl_addr;
        pend_data_d  = bus.dl_data;
      end
    end else if (!req_valid_q && pend_valid_q && (pend_addr_q[0] || !bus.dl_active)) begin
      w_load       = 1'b1;
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_port_d  = req_port_q;
    req_a_d     = req_a_q;
    req_ds_d    = req_ds_q;
    req_d_d     = req_d_q;
    p1_req_d    = p1_req_q;
    p2_req_d    = p2_req_q;
    case (state_q)
      S_IDLE: begin
        if (w_load) begin
          req_valid_d = 1'b1;
          req_port_d  = w_hi;
          req_a_d     = w_off[23:1];
          req_ds_d    = w_load_ds;
          req_d_d     = w_load_d;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_port_q) p2_req_d = ~p2_req_q;
        else            p1_req_d = ~p1_req_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (req_port_q ? (p2_req_q == bus.port2_ack) : (p1_req_q == bus.port1_ack)) begin
          req_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // armed_q keeps dl_done from rising before any download has been seen.
    armed_d = armed_q | bus.dl_active;
    done_d  = done_q;
    if (bus.dl_active && !act_q) begin
      done_d = 1'b0;
    end else if (armed_q && !bus.dl_active && !pend_valid_q && !req_valid_q) begin
      done_d  = 1'b1;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      req_valid_q  <= 1'b0;
      req_port_q   <= 1'b0;
      req_a_q      <= '0;
      req_ds_q     <= '0;
      req_d_q      <= '0;
      p1_req_q     <= bus.port1_ack;
      p2_req_q     <= bus.port2_ack;
      act_q        <= 1'b0;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      req_valid_q  <= req_valid_d;
      req_port_q   <= req_port_d;
      req_a_q      <= req_a_d;
      req_ds_q     <= req_ds_d;
      req_d_q      <= req_d_d;
      p1_req_q     <= p1_req_d;
      p2_req_q     <= p2_req_d;
      act_q        <= bus.dl_active;
      armed_q      <= armed_d;
      done_q       <= done_d;
    end
  end

  assign bus.dl_wait   = w_wait;
  assign bus.dl_done   = done_q;
  assign bus.port1_req = p1_req_q;
  assign bus.port1_we  = 1'b1;
  assign bus.port1_a   = req_a_q;
  assign bus.port1_ds  = req_ds_q;
  assign bus.port1_d   = req_d_q;
  assign bus.port2_req = p2_req_q;
  assign bus.port2_we  = 1'b1;
  assign bus.port2_a   = req_a_q;
  assign bus.port2_ds  = req_ds_q;
  assign bus.port2_d   = req_d_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_rom_loader.sv
//----------------------------------------------------------------------------
// tb_sdram_rom_loader : random and directed download streams checked against a byte-pairing model. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_sdram_rom_loader;

  localparam logic [24:0] GFX = 25'h0080000;

  typedef struct packed {
    logic        port;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    int          gap;
  } byte_t;

  logic  clk = 1'b0;
  logic  reset;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    ack_delay = 0;
  bit    resp_busy = 1'b0;
  bit    wait_seen = 1'b0;
  wr_t   got[$];
  byte_t bq[$];

  always #5 clk = ~clk;

  sdram_rom_loader_if #(.ADDR_W(25)) bus ();

  sdram_rom_loader #(.ADDR_W(25), .GFX_BASE(GFX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // SDRAM controller stand-in: toggles ack ack_delay cycles after seeing a request.
  initial begin
    bit p;
    bus.port1_ack = 1'b0;
    bus.port2_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.port1_req !== bus.port1_ack || bus.port2_req !== bus.port2_ack) begin
        p = (bus.port2_req !== bus.port2_ack);
        resp_busy = 1'b1;
        repeat (ack_delay) @(negedge clk);
        got.push_back(p ? wr_t'{1'b1, bus.port2_a, bus.port2_ds, bus.port2_d}
                        : wr_t'{1'b0, bus.port1_a, bus.port1_ds, bus.port1_d});
        if (p) bus.port2_ack = ~bus.port2_ack;
        else   bus.port1_ack = ~bus.port1_ack;
        resp_busy = 1'b0;
      end
    end
  end

  function automatic wr_t mk(input logic [24:0] a, input logic [1:0] ds, input logic [15:0] d);
    wr_t         w;
    logic [24:0] off;
    w.port = (a >= GFX);
    off    = w.port ? a - GFX : a;
    w.a    = off[23:1];
    w.ds   = ds;
    w.d    = d;
    return w;
  endfunction

  // Greedy pairing: an even byte followed directly by its odd neighbour is one word.
  task automatic build_expected(output wr_t exp[$]);
    int i = 0;
    exp.delete();
    while (i < bq.size()) begin
      if (!bq[i].a[0] && i + 1 < bq.size() && bq[i+1].a == bq[i].a + 25'd1) begin
        exp.push_back(mk(bq[i].a, 2'b11, {bq[i+1].d, bq[i].d}));
        i += 2;
      end else begin
        exp.push_back(mk(bq[i].a, bq[i].a[0] ? 2'b10 : 2'b01, {bq[i].d, bq[i].d}));
        i += 1;
      end
    end
  endtask

  task automatic send_byte(input byte_t b);
    int n = 0;
    if (b.gap > 0) begin
      bus.dl_wr = 1'b0;
      repeat (b.gap) @(negedge clk);
    end
    bus.dl_wr   = 1'b1;
    bus.dl_addr = b.a;
    bus.dl_data = b.d;
    while (bus.dl_wait === 1'b1 && n < 2000) begin
      wait_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq("accept_timeout", 64'(n), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_dl(input string tag, input int hold);
    wr_t exp[$];
    int  n = 0;
    build_expected(exp);
    got.delete();
    @(negedge clk);
    bus.dl_active = 1'b1;
    @(negedge clk);
    check_eq({tag, "_done_clr"}, 64'(bus.dl_done), 64'd0);
    foreach (bq[k]) send_byte(bq[k]);
    bus.dl_wr = 1'b0;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check_eq({tag, "_hold_cnt"}, 64'(got.size()), 64'(exp.size() - 1));
      check_eq({tag, "_hold_done"}, 64'(bus.dl_done), 64'd0);
    end
    bus.dl_active = 1'b0;
    if (exp.size() > 0 && ack_delay >= 5) begin
      repeat (2) @(negedge clk);
      check_eq({tag, "_done_early"}, 64'(bus.dl_done), 64'd0);
    end
    while (bus.dl_done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, 64'(bus.dl_done), 64'd1);
    check_eq({tag, "_nwr"}, 64'(got.size()), 64'(exp.size()));
    foreach (exp[k]) check_eq({tag, "_wr"}, (k < got.size()) ? 64'(got[k]) : 64'd0, 64'(exp[k]));
  endtask

  task automatic gen(input int nbytes, input logic [24:0] start, input bit gaps);
    logic [24:0] a = start;
    bq.delete();
    for (int k = 0; k < nbytes; k++) begin
      byte_t b;
      b.a   = a;
      b.d   = 8'($urandom);
      b.gap = (gaps && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 0;
      bq.push_back(b);
      a = a + (($urandom_range(0, 7) == 0) ? 25'($urandom_range(2, 4)) : 25'd1);
    end
  endtask

  task automatic check_image();
    logic [7:0]  ref_img[int];
    logic [7:0]  dut_img[int];
    logic [24:0] base;
    foreach (bq[k]) ref_img[int'(bq[k].a)] = bq[k].d;
    foreach (got[k]) begin
      base = (got[k].port ? GFX : 25'd0) + {1'b0, got[k].a, 1'b0};
      if (got[k].ds[0]) dut_img[int'(base)]         = got[k].d[7:0];
      if (got[k].ds[1]) dut_img[int'(base + 25'd1)] = got[k].d[15:8];
    end
    foreach (ref_img[key])
      check_eq("image", dut_img.exists(key) ? 64'(dut_img[key]) : 64'hdead, 64'(ref_img[key]));
  endtask

  function automatic byte_t bt(input logic [24:0] a, input logic [7:0] d);
    byte_t b;
    b.a = a; b.d = d; b.gap = 0;
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic p_before;
    int   n;
    reset         = 1'b1;
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_addr   = '0;
    bus.dl_data   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_wait", 64'(bus.dl_wait), 64'd0);
    check_eq("rst_done", 64'(bus.dl_done), 64'd0);
    check_eq("rst_p1_out", {bus.port1_we, bus.port1_a, bus.port1_ds, bus.port1_d}, {1'b1, 41'd0});
    check_eq("rst_p2_out", {bus.port2_we, bus.port2_a, bus.port2_ds, bus.port2_d}, {1'b1, 41'd0});
    check_eq("rst_req", {bus.port1_req, bus.port2_req}, {bus.port1_ack, bus.port2_ack});
    reset = 1'b0;

    ack_delay = 10;
    bq.delete(); bq.push_back(bt(25'd0, 8'h11)); bq.push_back(bt(25'd1, 8'h22));
    run_dl("pair_p1", 0);
    check_eq("pair_p1_word", 64'(got[0]), 64'(wr_t'{1'b0, 23'd0, 2'b11, 16'h2211}));

    ack_delay = 3;
    p_before = bus.port1_req;
    bq.delete(); bq.push_back(bt(GFX, 8'h5A)); bq.push_back(bt(GFX + 25'd1, 8'hA5));
    run_dl("pair_p2", 0);
    check_eq("pair_p2_word", 64'(got[0]), 64'(wr_t'{1'b1, 23'd0, 2'b11, 16'hA55A}));
    check_eq("pair_p2_p1req", 64'(bus.port1_req), 64'(p_before));

    bq.delete(); bq.push_back(bt(25'd5, 8'hAA));
    run_dl("odd_single", 0);
    check_eq("odd_single_word", 64'(got[0]), 64'(wr_t'{1'b0, 23'd2, 2'b10, 16'hAAAA}));

    ack_delay = 2;
    bq.delete(); bq.push_back(bt(25'd4, 8'h33)); bq.push_back(bt(25'd8, 8'h44));
    run_dl("hold_pend", 30);

    bq.delete(); bq.push_back(bt(25'h1FFFFFF, 8'hC1)); bq.push_back(bt(25'd0, 8'hC2));
    run_dl("wrap", 0);

    bq.delete();
    run_dl("empty", 0);

    // Reset while a port1 word is in WAIT.
    ack_delay = 40;
    got.delete();
    bus.dl_active = 1'b1;
    send_byte(bt(25'h10, 8'h55));
    send_byte(bt(25'h11, 8'h66));
    bus.dl_wr = 1'b0;
    n = 0;
    while (bus.port1_req === bus.port1_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_mid_inflight", 64'(bus.port1_req != bus.port1_ack), 64'd1);
    reset = 1'b1;
    bus.dl_active = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_req", 64'(bus.port1_req), 64'(bus.port1_ack));
    check_eq("rst_mid_wait", 64'(bus.dl_wait), 64'd0);
    check_eq("rst_mid_done", 64'(bus.dl_done), 64'd0);
    n = 0;
    while (resp_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst_mid_no_toggle", {bus.port1_req, bus.port2_req}, {bus.port1_ack, bus.port2_ack});

    // Slow acks under a continuous stream force back-pressure.
    ack_delay = 20;
    wait_seen = 1'b0;
    gen(64, GFX - 25'd24, 1'b0);
    run_dl("stream64", 0);
    check_eq("stream64_wait_seen", 64'(wait_seen), 64'd1);
    check_image();

    for (int r = 0; r < 3; r++) begin
      ack_delay = int'($urandom_range(0, 4));
      gen(24, 25'($urandom_range(0, 255)) + (r[0] ? GFX - 25'd8 : 25'd0), 1'b1);
      run_dl("rand", 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
